// File: rtl/mem_io_bus_ctrl.sv
// Shared data-memory / MMIO bus sequencer. Arbitrates the CPU load/store port and the UART
// programmer port (round robin on ties), runs one transaction at a time and returns a
// one-cycle ack with read data to the owning port.
module mem_io_bus_ctrl #(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [21:0] IO_HI   = 22'h3FFFFF
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        upg_req,
  input  logic        upg_we,
  input  logic [31:0] upg_addr,
  input  logic [31:0] upg_wdata,
  output logic        upg_ack,
  output logic [31:0] upg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [9:0]  io_addr_low,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        led_cs,
  output logic        sw_cs,
  output logic        dig_cs,
  output logic        bus_owner
);

  typedef enum logic [2:0] {StIdle, StMemAcc, StMemWait, StIoAcc, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;          // 0 = CPU, 1 = upg
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] upg_rdata_q, upg_rdata_d;

  logic        gnt_upg;
  logic [31:0] sel_addr;
  logic        led_hit, sw_hit, dig_hit;
  logic        cap_en;
  logic [31:0] cap_data;

  // On a tie the port that did not win last time is granted
  assign gnt_upg  = upg_req & (~cpu_req | ~last_grant_q);
  assign sel_addr = gnt_upg ? upg_addr : cpu_addr;

  assign led_hit = (addr_q[9:0] == 10'h060) || (addr_q[9:0] == 10'h062);
  assign sw_hit  = (addr_q[9:0] == 10'h070) || (addr_q[9:0] == 10'h072);
  assign dig_hit = (addr_q[9:0] == 10'h080) || (addr_q[9:0] == 10'h082);

  // State and transaction registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      upg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      upg_rdata_q  <= upg_rdata_d;
    end
  end

  // Next-state, request latching and read-data capture
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    upg_rdata_d  = upg_rdata_q;
    cap_en       = 1'b0;
    cap_data     = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || upg_req) begin
          owner_d      = gnt_upg;
          last_grant_d = gnt_upg;
          we_d         = gnt_upg ? upg_we : cpu_we;
          addr_d       = sel_addr;
          wdata_d      = gnt_upg ? upg_wdata : cpu_wdata;
          state_d      = (sel_addr[31:10] == IO_HI) ? StIoAcc : StMemAcc;
        end
      end
      StMemAcc: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          state_d = StMemWait;
          cnt_d   = 3'(MEM_LAT);
        end
      end
      StMemWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          cap_en   = 1'b1;
          cap_data = mem_rdata;
          state_d  = StResp;
        end
      end
      StIoAcc: begin
        // Only the switch block is readable; every other IO read returns zero
        cap_en   = ~we_q;
        cap_data = sw_hit ? {16'h0000, io_rdata} : 32'h0;
        state_d  = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (cap_en) begin
      if (owner_q) begin
        upg_rdata_d = cap_data;
      end else begin
        cpu_rdata_d = cap_data;
      end
    end
  end

  // Moore outputs decoded from state and latched request
  always_comb begin
    cpu_ack     = 1'b0;
    upg_ack     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    io_rd       = 1'b0;
    io_wr       = 1'b0;
    io_addr_low = '0;
    io_wdata    = '0;
    led_cs      = 1'b0;
    sw_cs       = 1'b0;
    dig_cs      = 1'b0;
    unique case (state_q)
      StMemAcc: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      StIoAcc: begin
        io_rd       = ~we_q;
        io_wr       = we_q;
        io_addr_low = addr_q[9:0];
        io_wdata    = wdata_q[15:0];
        led_cs      = led_hit & we_q;
        sw_cs       = sw_hit & ~we_q;
        dig_cs      = dig_hit & we_q;
      end
      StResp: begin
        cpu_ack = ~owner_q;
        upg_ack = owner_q;
      end
      default: begin
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign upg_rdata = upg_rdata_q;
  assign bus_owner = owner_q;

endmodule

// File: tb/tb_mem_io_bus_ctrl.sv
// Self-checking bench for mem_io_bus_ctrl: directed scenarios plus randomized single and
// contended transactions checked against a transaction-level model of the bus.
`timescale 1ns/1ps
module tb_mem_io_bus_ctrl;

  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        upg_req = 1'b0, upg_we = 1'b0;
  logic [31:0] upg_addr = '0, upg_wdata = '0;
  logic        cpu_ack, cpu_stall, upg_ack;
  logic [31:0] cpu_rdata, upg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        io_rd, io_wr;
  logic [9:0]  io_addr_low;
  logic [15:0] io_wdata, io_rdata;
  logic        led_cs, sw_cs, dig_cs, bus_owner;
  logic [15:0] sw_val = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_io_bus_ctrl #(.MEM_LAT(LAT), .IO_HI(22'h3FFFFF)) dut (
    .clock(clock), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .upg_req(upg_req), .upg_we(upg_we), .upg_addr(upg_addr), .upg_wdata(upg_wdata),
    .upg_ack(upg_ack), .upg_rdata(upg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr_low(io_addr_low), .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .led_cs(led_cs), .sw_cs(sw_cs), .dig_cs(dig_cs), .bus_owner(bus_owner)
  );

  logic [163:0] outs;
  assign outs = {cpu_ack, upg_ack, mem_en, mem_we, mem_addr, mem_wdata, io_rd, io_wr,
                 io_addr_low, io_wdata, led_cs, sw_cs, dig_cs, bus_owner, cpu_rdata, upg_rdata};

  // Data memory device: read data appears LAT cycles after the enable cycle, garbage otherwise
  bit [31:0] dev_mem [64];
  bit [32:0] rd_pipe [LAT];
  always @(posedge clock) begin
    if (mem_en && mem_we) dev_mem[mem_addr[7:2]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? {1'b1, dev_mem[mem_addr[7:2]]} : 33'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1][32] ? rd_pipe[LAT-1][31:0] : 32'hDEAD_BEEF;
  assign io_rdata  = sw_val;

  // Reference model state
  bit [31:0]   model_mem [64];
  bit          model_last = 1'b1;
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  bit          t_we [2];
  logic [31:0] t_ad [2];
  logic [31:0] t_wd [2];

  function automatic bit is_io(input logic [31:0] ad);
    return ad[31:10] == 22'h3FFFFF;
  endfunction
  function automatic bit is_sw(input logic [31:0] ad);
    return is_io(ad) && (ad[9:0] == 10'h070 || ad[9:0] == 10'h072);
  endfunction
  function automatic int lat_of(input bit we, input logic [31:0] ad);
    return (we || is_io(ad)) ? 2 : 2 + int'(LAT);
  endfunction

  task automatic set_req(input bit p, input bit v);
    if (p) upg_req = v; else cpu_req = v;
  endtask

  // Runs one transaction per requesting port (t_* indexed 0 = CPU, 1 = upg)
  task automatic run_txns(input bit do_c, input bit do_u, input bit early, input bit scramble);
    bit p [2]; bit we [2]; logic [31:0] ad [2]; logic [31:0] wd [2];
    int g [2]; int a [2]; int n; int k;
    bit io, ecack, euack;
    logic [9:0] low;
    logic [6:0] exp_strb;
    logic [31:0] exp_d;
    if (do_c && do_u) begin p[0] = ~model_last; p[1] = model_last; n = 2; end
    else begin p[0] = do_u; p[1] = ~do_u; n = 1; end
    for (int j = 0; j < 2; j++) begin we[j] = t_we[p[j]]; ad[j] = t_ad[p[j]]; wd[j] = t_wd[p[j]]; end
    g[0] = 0; a[0] = lat_of(we[0], ad[0]);
    g[1] = a[0] + 1; a[1] = g[1] + lat_of(we[1], ad[1]);
    model_last = p[n-1];
    cpu_we = t_we[0]; cpu_addr = t_ad[0]; cpu_wdata = t_wd[0]; cpu_req = do_c;
    upg_we = t_we[1]; upg_addr = t_ad[1]; upg_wdata = t_wd[1]; upg_req = do_u;
    for (int c = 1; c <= a[n-1]; c++) begin
      @(posedge clock); #1;
      k = (n == 2 && c > a[0]) ? 1 : 0;
      ecack = 1'b0; euack = 1'b0;
      for (int j = 0; j < n; j++) if (a[j] == c) begin if (p[j]) euack = 1'b1; else ecack = 1'b1; end
      n_checks++;
      if ({cpu_ack, upg_ack, cpu_stall} !== {ecack, euack, cpu_req & ~ecack}) begin
        n_fail++;
        $display("FAIL ack/stall cycle %0d: got %b required %b", c,
                 {cpu_ack, upg_ack, cpu_stall}, {ecack, euack, cpu_req & ~ecack});
      end
      io = is_io(ad[k]); low = ad[k][9:0];
      exp_strb = '0;
      if (c == g[k] + 1)
        exp_strb = {!io, !io && we[k], io && !we[k], io && we[k],
                    io && we[k] && (low == 10'h060 || low == 10'h062),
                    io && !we[k] && (low == 10'h070 || low == 10'h072),
                    io && we[k] && (low == 10'h080 || low == 10'h082)};
      n_checks++;
      if ({mem_en, mem_we, io_rd, io_wr, led_cs, sw_cs, dig_cs} !== exp_strb) begin
        n_fail++;
        $display("FAIL strobes cycle %0d addr %h: got %b required %b", c, ad[k],
                 {mem_en, mem_we, io_rd, io_wr, led_cs, sw_cs, dig_cs}, exp_strb);
      end
      if (c == g[k] + 1) begin
        n_checks++;
        if (bus_owner !== p[k] || (!io && mem_addr !== ad[k]) ||
            (!io && we[k] && mem_wdata !== wd[k]) || (io && io_addr_low !== low) ||
            (io && we[k] && io_wdata !== wd[k][15:0])) begin
          n_fail++;
          $display("FAIL bus fields: got own=%b maddr=%h mwd=%h ioa=%h iowd=%h required own=%b addr=%h wd=%h",
                   bus_owner, mem_addr, mem_wdata, io_addr_low, io_wdata, p[k], ad[k], wd[k]);
        end
        if (early) set_req(p[k], 1'b0);
        if (scramble) begin
          if (p[k]) begin upg_addr = $urandom; upg_wdata = $urandom; end
          else begin cpu_addr = $urandom; cpu_wdata = $urandom; end
        end
      end
      for (int j = 0; j < n; j++) begin
        if (a[j] == c) begin
          exp_d = exp_rdata[p[j]];
          if (!we[j]) exp_d = is_io(ad[j]) ? (is_sw(ad[j]) ? {16'h0, sw_val} : 32'h0)
                                           : model_mem[ad[j][7:2]];
          else if (!is_io(ad[j])) model_mem[ad[j][7:2]] = wd[j];
          exp_rdata[p[j]] = exp_d;
          n_checks++;
          if (bus_owner !== p[j] || (p[j] ? upg_rdata : cpu_rdata) !== exp_d) begin
            n_fail++;
            $display("FAIL rdata port %0d addr %h: got own=%b data=%h required own=%b data=%h",
                     p[j], ad[j], bus_owner, p[j] ? upg_rdata : cpu_rdata, p[j], exp_d);
          end
          set_req(p[j], 1'b0);
        end
      end
    end
    @(posedge clock); #1;
    n_checks++;
    if ({cpu_ack, upg_ack, mem_en, io_rd, io_wr} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle after txn: got %b required 00000", {cpu_ack, upg_ack, mem_en, io_rd, io_wr});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock); #1;
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset outputs: got %h required 0", outs); end
    rst_n = 1'b1;
    @(posedge clock); #1;
    sw_val = 16'h5A5A; t_we[0] = 1'b0; t_ad[0] = 32'hFFFF_FC70; t_wd[0] = '0;
    run_txns(1'b1, 1'b0, 1'b0, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    repeat (2) @(posedge clock); #1;
    rst_n = 1'b0; #1;
    n_checks++;
    if (outs !== '0 || cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL mid-wait reset: got %h stall %b required 0 stall 1", outs, cpu_stall);
    end
    cpu_req = 1'b0; model_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    @(posedge clock); #1; rst_n = 1'b1;
    t_we[0] = 1'b1; t_ad[0] = 32'h0000_0030; t_wd[0] = 32'h1111_2222;
    t_we[1] = 1'b1; t_ad[1] = 32'h0000_0034; t_wd[1] = 32'h3333_4444;
    run_txns(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mem_write();
    t_we[0] = 1'b1; t_ad[0] = 32'h0000_0010; t_wd[0] = 32'h1234_5678;
    run_txns(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mem_read();
    t_we[0] = 1'b0; t_ad[0] = 32'h0000_0010;
    run_txns(1'b1, 1'b0, 1'b0, 1'b0);
    t_we[1] = 1'b0; t_ad[1] = 32'h0000_0034;
    run_txns(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_io();
    t_we[0] = 1'b1; t_ad[0] = 32'hFFFF_FC60; t_wd[0] = 32'hABCD_1234;
    run_txns(1'b1, 1'b0, 1'b0, 1'b0);
    sw_val = 16'h00F0; t_we[0] = 1'b0; t_ad[0] = 32'hFFFF_FC70;
    run_txns(1'b1, 1'b0, 1'b0, 1'b0);
    t_we[1] = 1'b1; t_ad[1] = 32'hFFFF_FC82; t_wd[1] = 32'h0000_BEEF;
    run_txns(1'b0, 1'b1, 1'b0, 1'b0);
    sw_val = 16'hC3A5; t_we[1] = 1'b0; t_ad[1] = 32'hFFFF_FC72;
    run_txns(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    sw_val = 16'hFFFF; t_we[0] = 1'b0; t_ad[0] = 32'hFFFF_FC44;
    run_txns(1'b1, 1'b0, 1'b0, 1'b0);
    t_we[1] = 1'b1; t_ad[1] = 32'hFFFF_FC44; t_wd[1] = 32'h5555_AAAA;
    run_txns(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit exp_p; int acks;
    rst_n = 1'b0; model_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    @(posedge clock); #1; rst_n = 1'b1;
    cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hC0C0_0001; cpu_req = 1'b1;
    upg_we = 1'b1; upg_addr = 32'h0000_0024; upg_wdata = 32'h0F0F_0002; upg_req = 1'b1;
    exp_p = ~model_last; acks = 0;
    for (int c = 1; c <= 20 && acks < 4; c++) begin
      @(posedge clock); #1;
      if (cpu_ack || upg_ack) begin
        n_checks++;
        if (upg_ack !== exp_p || cpu_ack !== !exp_p || c != 3 * acks + 2) begin
          n_fail++;
          $display("FAIL back-to-back ack %0d: got cpu=%b upg=%b at cycle %0d required upg=%b at cycle %0d",
                   acks, cpu_ack, upg_ack, c, exp_p, 3 * acks + 2);
        end
        model_last = exp_p; exp_p = ~exp_p; acks++;
      end
    end
    cpu_req = 1'b0; upg_req = 1'b0;
    model_mem[8] = 32'hC0C0_0001; model_mem[9] = 32'h0F0F_0002;
    n_checks++;
    if (acks != 4) begin n_fail++; $display("FAIL back-to-back count: got %0d required 4", acks); end
    @(posedge clock); #1;
    t_we[0] = 1'b0; t_ad[0] = 32'h0000_0024; t_we[1] = 1'b0; t_ad[1] = 32'h0000_0020;
    run_txns(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic gen_txn(input bit p);
    int kind; logic [21:0] hi; logic [9:0] low;
    kind = $urandom_range(0, 5);
    t_wd[p] = $urandom;
    t_we[p] = 1'($urandom_range(0, 1));
    low = 10'h044;
    case (kind)
      2: begin t_we[p] = 1'b1; low = ($urandom_range(0, 1) != 0) ? 10'h060 : 10'h082; end
      3: begin t_we[p] = 1'b0; low = ($urandom_range(0, 1) != 0) ? 10'h070 : 10'h072; end
      4: low = ($urandom_range(0, 1) != 0) ? 10'h100 : 10'h3FC;
      default: begin end
    endcase
    if (kind >= 2 && kind <= 4) begin
      t_ad[p] = {22'h3FFFFF, low};
    end else begin
      hi = 22'($urandom);
      if (hi == 22'h3FFFFF) hi = '0;
      t_ad[p] = {hi, 2'b00, 6'($urandom_range(0, 63)), 2'b00};
    end
  endtask

  task automatic test_random();
    int mode;
    for (int it = 0; it < 60; it++) begin
      sw_val = 16'($urandom);
      gen_txn(1'b0); gen_txn(1'b1);
      mode = $urandom_range(0, 2);
      run_txns(mode != 1, mode != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_mem_read();
    test_io();
    test_unmapped();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
